// File: rtl/mxv_result_drain.sv
// Result drain for the matrix-vector multiply datapath: pops N words from the
// result FIFO into a local buffer, sums them, then streams them out on valid/ready.
module mxv_result_drain #(
    parameter int WORD_LENGTH = 8,
    parameter int MAX_LENGTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WORD_LENGTH-1:0]   Matrix_length,
    input  logic [WORD_LENGTH-1:0]   fifo_data,
    input  logic                     fifo_empty,
    output logic                     fifo_pop,
    output logic [WORD_LENGTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_LENGTH+2:0]   result_sum,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int IDX_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam logic [WORD_LENGTH-1:0] ONE = WORD_LENGTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [WORD_LENGTH-1:0]   len_q;
    logic [IDX_W-1:0]         widx_q;
    logic [IDX_W-1:0]         sidx_q;
    logic [WORD_LENGTH-1:0]   buf_q [MAX_LENGTH];
    logic [WORD_LENGTH+2:0]   sum_q;
    logic                     error_q;

    logic len_ok;
    logic last_w;
    logic last_s;

    assign len_ok = (Matrix_length != '0) && (int'(Matrix_length) <= MAX_LENGTH);
    assign last_w = (WORD_LENGTH'(widx_q) == len_q - ONE);
    assign last_s = (WORD_LENGTH'(sidx_q) == len_q - ONE);

    // Pop is gated by the live empty flag so it can never fire on an empty FIFO.
    assign fifo_pop   = (state_q == S_POP) && !fifo_empty;
    assign out_valid  = (state_q == S_SEND);
    assign out_data   = buf_q[sidx_q];
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
    assign result_sum = sum_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            sidx_q  <= '0;
            sum_q   <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < MAX_LENGTH; i++) buf_q[i] <= '0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len_q   <= Matrix_length;
                            widx_q  <= '0;
                            sidx_q  <= '0;
                            sum_q   <= '0;
                            state_q <= S_POP;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_POP: begin
                    if (!fifo_empty) state_q <= S_CAPTURE;
                end
                // FIFO read data lands the cycle after the pop.
                S_CAPTURE: begin
                    buf_q[widx_q] <= fifo_data;
                    sum_q         <= sum_q + {3'b000, fifo_data};
                    if (last_w) begin
                        sidx_q  <= '0;
                        state_q <= S_SEND;
                    end else begin
                        widx_q  <= widx_q + 1'b1;
                        state_q <= S_POP;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (last_s) state_q <= S_DONE;
                        else        sidx_q  <= sidx_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mxv_result_drain.sv
// Directed bench for mxv_result_drain: FIFO model, negedge monitor, and
// immediate-assertion checks against hand-computed expectations.
module tb_mxv_result_drain;

    logic        clk = 1'b0;
    logic        reset, start, fifo_empty, fifo_pop, out_valid, out_ready;
    logic        busy, done, error, stall;
    logic [7:0]  Matrix_length, out_data;
    logic [7:0]  fifo_data = 8'h00;
    logic [10:0] result_sum;

    always #5 clk = ~clk;

    mxv_result_drain #(.WORD_LENGTH(8), .MAX_LENGTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .Matrix_length(Matrix_length),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .result_sum(result_sum), .busy(busy), .done(done), .error(error)
    );

    // FIFO model: registered read data, appended to by load()
    logic [7:0] mem [0:63];
    int rptr = 0;
    int wcnt = 0;
    assign fifo_empty = stall || (rptr == wcnt);
    always @(posedge clk) if (fifo_pop) begin
        fifo_data <= mem[rptr];
        rptr      <= rptr + 1;
    end

    // Monitor
    int cyc = 0, npop = 0, ndone = 0, nerr = 0, nbad = 0, nstab = 0, done_cyc = 0;
    int pop_cyc[$];
    int xc[$];
    logic [7:0] xq[$];
    logic [7:0] prev_d = 8'h00;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (fifo_pop) begin
            npop++;
            pop_cyc.push_back(cyc);
            if (fifo_empty) nbad++;
        end
        if (done) begin ndone++; done_cyc = cyc; end
        if (error) nerr++;
        if (prev_stall && out_valid && out_data !== prev_d) nstab++;
        if (out_valid && out_ready) begin xq.push_back(out_data); xc.push_back(cyc); end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
    end

    int total = 0, passed = 0, failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input int n, input logic [7:0] base, input logic [7:0] inc);
        for (int i = 0; i < n; i++) mem[wcnt + i] = base + inc * 8'(i);
        wcnt = wcnt + n;
    endtask

    task automatic go(input logic [7:0] n);
        Matrix_length = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        for (int k = 0; k < 200 && ndone <= base; k++) tick();
        chk("done_seen", 32'(ndone > base), 1);
    endtask

    int sc, bp, bx, bd, be;
    logic [5:0] pat = 6'b110100;

    initial begin
        reset = 1'b0; start = 1'b0; Matrix_length = 8'd0; out_ready = 1'b0; stall = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_pop", 32'(fifo_pop), 0);
        chk("rst_sum", 32'(result_sum), 0);
        chk("rst_data", 32'(out_data), 0);
        reset = 1'b1;
        tick();

        // N=4: 10,20,30,40 with out_ready held high
        load(4, 8'd10, 8'd10);
        bp = npop; bx = xq.size(); bd = ndone;
        out_ready = 1'b1;
        sc = cyc + 1;
        go(8'd4);
        chk("t1_busy_T1", 32'(busy), 1);
        chk("t1_pop_T1", 32'(fifo_pop), 1);
        wait_done(bd);
        chk("t1_done_lat", 32'(done_cyc - sc), 13);
        chk("t1_npop", 32'(npop - bp), 4);
        chk("t1_first_pop", 32'(pop_cyc[bp] - sc), 1);
        for (int k = 1; k < 4; k++) chk("t1_pop_gap", 32'(pop_cyc[bp + k] - pop_cyc[bp + k - 1]), 2);
        chk("t1_nxfer", 32'(xq.size() - bx), 4);
        for (int k = 0; k < 4; k++) chk("t1_word", 32'(xq[bx + k]), 32'(10 * (k + 1)));
        chk("t1_xfer_span", 32'(xc[bx + 3] - xc[bx]), 3);
        chk("t1_sum", 32'(result_sum), 100);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_done_once", 32'(ndone - bd), 1);

        // N=8, all 0xFF: sum must not overflow
        load(8, 8'hFF, 8'h00);
        bx = xq.size(); bd = ndone;
        go(8'd8);
        wait_done(bd);
        chk("t2_sum", 32'(result_sum), 32'h7F8);
        chk("t2_nxfer", 32'(xq.size() - bx), 8);
        chk("t2_last", 32'(xq[bx + 7]), 32'hFF);

        // Backpressure, N=3: 5,6,7 with ready 0,0,1,0,1,1
        load(3, 8'd5, 8'd1);
        bx = xq.size(); bd = ndone;
        out_ready = 1'b0;
        go(8'd3);
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        chk("t3_valid", 32'(out_valid), 1);
        for (int i = 0; i < 6; i++) begin
            out_ready = pat[i];
            if (i == 1) chk("t3_hold_w0", 32'(out_data), 5);
            if (i == 3) chk("t3_hold_w1", 32'(out_data), 6);
            tick();
        end
        out_ready = 1'b1;
        wait_done(bd);
        chk("t3_nxfer", 32'(xq.size() - bx), 3);
        for (int k = 0; k < 3; k++) chk("t3_word", 32'(xq[bx + k]), 32'(5 + k));
        chk("t3_stable", 32'(nstab), 0);

        // Empty stall for 5 cycles after the second pop
        load(4, 8'd1, 8'd1);
        bp = npop; bx = xq.size(); bd = ndone;
        go(8'd4);
        for (int k = 0; k < 50 && npop < bp + 2; k++) tick();
        stall = 1'b1;
        repeat (5) tick();
        chk("t4_no_pop_stall", 32'(npop - bp), 2);
        stall = 1'b0;
        wait_done(bd);
        chk("t4_npop", 32'(npop - bp), 4);
        for (int k = 0; k < 4; k++) chk("t4_word", 32'(xq[bx + k]), 32'(k + 1));
        chk("t4_sum", 32'(result_sum), 10);

        // Illegal lengths 0 and 9
        bp = npop; be = nerr;
        go(8'd0);
        chk("t5_err0", 32'(error), 1);
        chk("t5_busy0", 32'(busy), 0);
        tick();
        chk("t5_err_pulse", 32'(error), 0);
        go(8'd9);
        chk("t5_err9", 32'(error), 1);
        chk("t5_busy9", 32'(busy), 0);
        tick();
        chk("t5_nerr", 32'(nerr - be), 2);
        chk("t5_npop", 32'(npop - bp), 0);
        chk("t5_sum_held", 32'(result_sum), 10);

        // Reset during SEND after 2 of 4 words
        load(4, 8'd11, 8'd11);
        bx = xq.size();
        go(8'd4);
        for (int k = 0; k < 50 && xq.size() < bx + 2; k++) tick();
        chk("t6_sending", 32'(out_valid), 1);
        out_ready = 1'b0;
        reset = 1'b0;
        tick();
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_sum", 32'(result_sum), 0);
        reset = 1'b1;
        wcnt = rptr;
        tick();
        load(2, 8'd3, 8'd1);
        out_ready = 1'b1;
        bx = xq.size(); bd = ndone;
        go(8'd2);
        wait_done(bd);
        chk("t6_nxfer", 32'(xq.size() - bx), 2);
        chk("t6_w0", 32'(xq[bx]), 3);
        chk("t6_w1", 32'(xq[bx + 1]), 4);
        chk("t6_sum2", 32'(result_sum), 7);

        chk("pop_while_empty", 32'(nbad), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
